codec_config_sequencer: RTL and testbench
=========================================

Name: codec_config_sequencer

Overview:
- Upstream controller for the I2C write engine that programs the audio codec (device address 0x34).
- Steps through a fixed table of 11 codec register words and presents each as a 16-bit word, {7-bit register address, 9-bit data}, to the engine.
- Pulses the engine's ignition for each word, waits for its finish flag, and checks the three ACK bits; retries a failed word with a settle gap between transactions.
- Reports done or error to the top level.

Parameters:
- SETTLE_CYCLES, 50000: clk cycles with ignition low between transactions (1 ms at 50 MHz).
- MAX_RETRIES, 3: total attempts per word before declaring error.
- TIMEOUT_CYCLES, 1048575: clk cycles allowed per attempt, from ignition rise to finish; width 20 bits.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low
- start  in  1  level; begins the sequence from index 0 when in IDLE, DONE or ERROR
- i2c_finish  in  1  finish flag from the I2C engine
- i2c_ack  in  3  ACK bits from the engine; 3'b111 means all three bytes acknowledged
- i2c_word  out  16  register word to the engine
- i2c_ignition  out  1  enables the engine's transaction
- busy  out  1  high in every state except IDLE, DONE and ERROR
- done  out  1  high while in DONE
- error  out  1  high while in ERROR
- reg_index  out  4  table index currently being written
- retry_count  out  2  failed attempts on the current index

Behaviour:
- Reset is synchronous: clk is clock; reset is synchronous, active-low. When reset=0 on a clk edge:
  - state=IDLE; all outputs 0, including i2c_word=16'h0000; all counters cleared.
  - This applies mid-transaction: ignition drops the following cycle.
- Table (index: word), hard-coded:
  - 0:1E00, 1:0C00, 2:0017, 3:0217, 4:0479, 5:0679, 6:0812, 7:0A00, 8:0E02, 9:1000, 10:1201.
  - Last index is 10.
- States:
  - IDLE: ignition=0. If start=1, set reg_index=0 and retry_count=0, then go to LOAD.
  - LOAD (1 cycle): i2c_word <= table[reg_index]; clear the timeout counter; go to ARM.
  - ARM: i2c_ignition=1. Wait for i2c_finish=0, which rejects a stale finish left over from the previous transaction; then go to WAIT.
  - WAIT: i2c_ignition=1. On the first cycle with i2c_finish=1, go to CHECK.
  - Timeout in ARM/WAIT: the counter increments each cycle in ARM and WAIT. On reaching TIMEOUT_CYCLES-1, treat as a failed attempt and go to FAIL.
  - CHECK (1 cycle): i2c_ignition stays 1; sample i2c_ack.
    - ack==3'b111: go to PASS.
    - otherwise: go to FAIL.
  - PASS (1 cycle): i2c_ignition=0.
    - If reg_index==10: go to DONE.
    - Else: reg_index+1, retry_count=0, go to SETTLE.
  - FAIL (1 cycle): i2c_ignition=0; retry_count+1.
    - If the new count == MAX_RETRIES: go to ERROR.
    - Else: go to SETTLE with the index unchanged.
  - SETTLE: i2c_ignition=0; count SETTLE_CYCLES cycles; go to LOAD.
  - DONE / ERROR: i2c_ignition=0; hold reg_index and retry_count for debug. If start=1, restart exactly as from IDLE.
- Handshake timing:
  - i2c_word is stable from LOAD until the next LOAD.
  - i2c_word never changes while i2c_ignition=1.
- start while busy is ignored. start held high does not re-trigger until the sequence reaches DONE or ERROR; from there it restarts immediately.
- Reset taking effect in the same cycle as finish has priority: the result is IDLE.
- All outputs are registered; busy, done and error decode the registered state.

Test Plan:
- Nominal run (bench params SETTLE_CYCLES=4, TIMEOUT_CYCLES=200); model engine raises finish 20 cycles after ignition with ack=111 -> words 1E00, 0C00 … 1201 in order, 11 ignition pulses, done=1, busy=0, error=0, reg_index=10.
- Single NACK: ack=101 on the first attempt at index 4, then 111 -> word 0479 sent twice, retry_count shows 1 then resets to 0 at index 5, sequence completes with done=1.
- Persistent NACK at index 2 (MAX_RETRIES=3) -> exactly 3 ignition pulses carrying 0017, error=1, reg_index=2, retry_count=3, no word 0217 ever driven.
- Model never raises finish -> ignition drops after 200 cycles; after 3 timeouts error=1, with an ignition-low gap of at least 4 cycles between attempts.
- Finish held high from before start -> sequencer waits in ARM until finish falls, does not accept the stale flag, and the index does not advance.
- Reset low during WAIT at index 6 -> next cycle ignition=0, i2c_word=0000 and all flags 0; a subsequent start resends from word 1E00; start pulses during busy have no effect.

Source files
------------

// File: rtl/codec_config_sequencer_if.sv
// Register-word handshake between the codec config sequencer
// and the I2C write engine.
interface codec_config_sequencer_if;
    logic [15:0] i2c_word;
    logic        i2c_ignition;
    logic        i2c_finish;
    logic [2:0]  i2c_ack;

    modport master (
        output i2c_word,
        output i2c_ignition,
        input  i2c_finish,
        input  i2c_ack
    );

    modport slave (
        input  i2c_word,
        input  i2c_ignition,
        output i2c_finish,
        output i2c_ack
    );
endinterface

// File: rtl/codec_config_sequencer.sv
// Walks the audio codec init table through the I2C write engine,
// retrying NACKed or timed-out words and reporting done/error.
module codec_config_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 50000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    codec_config_sequencer_if.master i2c,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [3:0]               reg_index,
    output logic [1:0]               retry_count
);

    typedef enum logic [3:0] {
        IDLE, LOAD, ARM, WAIT, CHECK,
        PASS, FAIL, SETTLE, DONE, ERROR
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'd10;
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] SET_LAST = 20'(SETTLE_CYCLES - 1);
    localparam logic [1:0]  RTY_LAST = 2'(MAX_RETRIES - 1);

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  idx_d;
    logic [1:0]  rc_d;
    logic        ign_q, ign_d;
    logic        tmo;

    function automatic logic [15:0] tbl(input logic [3:0] i);
        case (i)
            4'd0:    tbl = 16'h1E00;
            4'd1:    tbl = 16'h0C00;
            4'd2:    tbl = 16'h0017;
            4'd3:    tbl = 16'h0217;
            4'd4:    tbl = 16'h0479;
            4'd5:    tbl = 16'h0679;
            4'd6:    tbl = 16'h0812;
            4'd7:    tbl = 16'h0A00;
            4'd8:    tbl = 16'h0E02;
            4'd9:    tbl = 16'h1000;
            4'd10:   tbl = 16'h1201;
            default: tbl = 16'h0000;
        endcase
    endfunction

    assign tmo = (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ARM refuses to leave while a stale finish from the last word is high
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = LOAD;
            LOAD:   state_d = ARM;
            ARM: begin
                if (tmo)                 state_d = FAIL;
                else if (!i2c.i2c_finish) state_d = WAIT;
            end
            WAIT: begin
                if (i2c.i2c_finish) state_d = CHECK;
                else if (tmo)       state_d = FAIL;
            end
            CHECK:  state_d = (i2c.i2c_ack == 3'b111) ? PASS : FAIL;
            PASS:   state_d = (reg_index == LAST_IDX) ? DONE : SETTLE;
            FAIL:   state_d = (retry_count == RTY_LAST) ? ERROR : SETTLE;
            SETTLE: if (cnt_q == SET_LAST) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        idx_d  = reg_index;
        rc_d   = retry_count;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    idx_d = 4'd0;
                    rc_d  = 2'd0;
                end
            end
            LOAD: begin
                word_d = tbl(reg_index);
                cnt_d  = 20'd0;
            end
            ARM, WAIT, SETTLE: cnt_d = cnt_q + 20'd1;
            PASS: begin
                cnt_d = 20'd0;
                if (reg_index != LAST_IDX) begin
                    idx_d = reg_index + 4'd1;
                    rc_d  = 2'd0;
                end
            end
            FAIL: begin
                cnt_d = 20'd0;
                rc_d  = retry_count + 2'd1;
            end
            default: ;
        endcase
        ign_d = (state_d == ARM) || (state_d == WAIT)
             || (state_d == CHECK);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q      <= 16'h0000;
            cnt_q       <= 20'd0;
            reg_index   <= 4'd0;
            retry_count <= 2'd0;
            ign_q       <= 1'b0;
        end else begin
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            reg_index   <= idx_d;
            retry_count <= rc_d;
            ign_q       <= ign_d;
        end
    end

    assign i2c.i2c_word     = word_q;
    assign i2c.i2c_ignition = ign_q;
    assign busy  = (state_q != IDLE) && (state_q != DONE)
                && (state_q != ERROR);
    assign done  = (state_q == DONE);
    assign error = (state_q == ERROR);

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural
// I2C engine that can NACK, stall, or hold a stale finish.
module tb_codec_config_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [3:0] reg_index;
    logic [1:0] retry_count;

    int total = 0;
    int bad   = 0;

    codec_config_sequencer_if bus ();

    codec_config_sequencer #(
        .SETTLE_CYCLES (4),
        .MAX_RETRIES   (3),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .i2c        (bus.master),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .reg_index  (reg_index),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_tbl [0:10] = '{
        16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201
    };

    // engine configuration, written by the stimulus process only
    logic        force_finish = 1'b0;
    logic        no_finish    = 1'b0;
    logic [15:0] nack_word    = 16'hFFFF;
    int          nack_limit   = 0;

    // engine and monitor state, written by the negedge process only
    int          mcnt = 0;
    int          nack_given = 0;
    logic        prev_ign = 1'b0;
    int          low_run = 0;
    int          high_run = 0;
    logic [15:0] words_q [$];
    logic [1:0]  rc_q [$];
    int          hi_q [$];
    int          gap_q [$];

    always @(negedge clk) begin
        if (bus.i2c_ignition && !prev_ign) begin
            words_q.push_back(bus.i2c_word);
            rc_q.push_back(retry_count);
            gap_q.push_back(low_run);
            high_run = 0;
        end
        if (!bus.i2c_ignition && prev_ign) begin
            hi_q.push_back(high_run);
            low_run = 0;
        end
        if (bus.i2c_ignition) high_run++;
        else                  low_run++;
        prev_ign = bus.i2c_ignition;

        if (!reset) nack_given = 0;
        if (force_finish) begin
            bus.i2c_finish = 1'b1;
            bus.i2c_ack    = 3'b111;
            mcnt = 0;
        end else if (bus.i2c_ignition && !no_finish) begin
            mcnt++;
            if (mcnt == 20) begin
                if (bus.i2c_word == nack_word && nack_given < nack_limit) begin
                    bus.i2c_ack = 3'b101;
                    nack_given++;
                end else begin
                    bus.i2c_ack = 3'b111;
                end
            end
            bus.i2c_finish = (mcnt >= 20);
        end else begin
            mcnt = 0;
            bus.i2c_finish = 1'b0;
            bus.i2c_ack    = 3'b000;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done || error), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b, hb, cnt, miss, ok, n;

        bus.i2c_finish = 1'b0;
        bus.i2c_ack    = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, done, error, bus.i2c_ignition}, 4'b0000);
        chk("rst_word", bus.i2c_word, 16'h0000);
        chk("rst_idx", {reg_index, retry_count}, 6'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_flags", {busy, done, error}, 3'b000);

        // nominal run
        b = words_q.size();
        pulse_start();
        chk("nom_busy", busy, 1'b1);
        wait_end("nom_end");
        chk("nom_flags", {busy, done, error}, 3'b010);
        chk("nom_idx", reg_index, 4'd10);
        chk("nom_pulses", words_q.size() - b, 11);
        miss = 0;
        for (int i = 0; i < 11; i++)
            if (words_q[b + i] != exp_tbl[i]) miss++;
        chk("nom_words", miss, 0);
        ok = 1;
        for (int i = 1; i < 11; i++)
            if (gap_q[b + i] < 4) ok = 0;
        chk("nom_gap", ok, 1);

        // single NACK at index 4
        do_reset();
        nack_word  = 16'h0479;
        nack_limit = 1;
        b = words_q.size();
        pulse_start();
        wait_end("nack1_end");
        chk("nack1_done", {done, error}, 2'b10);
        chk("nack1_pulses", words_q.size() - b, 12);
        chk("nack1_w4a", words_q[b + 4], 16'h0479);
        chk("nack1_w4b", words_q[b + 5], 16'h0479);
        chk("nack1_rc1", rc_q[b + 5], 2'd1);
        chk("nack1_w5", words_q[b + 6], 16'h0679);
        chk("nack1_rc0", rc_q[b + 6], 2'd0);

        // persistent NACK at index 2
        do_reset();
        nack_word  = 16'h0017;
        nack_limit = 3;
        b = words_q.size();
        pulse_start();
        wait_end("nack3_end");
        chk("nack3_flags", {busy, done, error}, 3'b001);
        chk("nack3_idx", reg_index, 4'd2);
        chk("nack3_rc", retry_count, 2'd3);
        chk("nack3_pulses", words_q.size() - b, 5);
        cnt = 0;
        miss = 0;
        for (int i = b; i < words_q.size(); i++) begin
            if (words_q[i] == 16'h0017) cnt++;
            if (words_q[i] == 16'h0217) miss++;
        end
        chk("nack3_0017", cnt, 3);
        chk("nack3_no0217", miss, 0);
        nack_limit = 0;

        // engine never finishes
        do_reset();
        no_finish = 1'b1;
        b  = words_q.size();
        hb = hi_q.size();
        pulse_start();
        wait_end("tmo_end");
        chk("tmo_flags", {done, error}, 2'b01);
        chk("tmo_rc", retry_count, 2'd3);
        chk("tmo_idx", reg_index, 4'd0);
        chk("tmo_pulses", words_q.size() - b, 3);
        chk("tmo_len0", hi_q[hb], 200);
        chk("tmo_len2", hi_q[hb + 2], 200);
        chk("tmo_gap", 32'((gap_q[b + 1] >= 4) && (gap_q[b + 2] >= 4)), 1);
        no_finish = 1'b0;

        // stale finish held before start
        do_reset();
        force_finish = 1'b1;
        b = words_q.size();
        pulse_start();
        repeat (50) @(negedge clk);
        chk("stale_ign", {busy, bus.i2c_ignition}, 2'b11);
        chk("stale_idx", reg_index, 4'd0);
        chk("stale_pulses", words_q.size() - b, 1);
        force_finish = 1'b0;
        wait_end("stale_end");
        chk("stale_done", {done, error}, 2'b10);
        chk("stale_total", words_q.size() - b, 11);
        chk("stale_w1", words_q[b + 1], 16'h0C00);

        // reset during WAIT at index 6, then restart with stray starts
        do_reset();
        pulse_start();
        n = 0;
        while (!(reg_index == 4'd6 && bus.i2c_ignition) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach6", 32'(reg_index == 4'd6 && bus.i2c_ignition), 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ign", bus.i2c_ignition, 1'b0);
        chk("mid_word", bus.i2c_word, 16'h0000);
        chk("mid_flags", {busy, done, error, reg_index, retry_count}, 9'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        b = words_q.size();
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        wait_end("mid_end");
        chk("mid_done", {done, error}, 2'b10);
        chk("mid_first", words_q[b], 16'h1E00);
        chk("mid_pulses", words_q.size() - b, 11);
        miss = 0;
        for (int i = 0; i < 11; i++)
            if (words_q[b + i] != exp_tbl[i]) miss++;
        chk("mid_words", miss, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
